// File: rtl/pacman_game_timer.sv
// Game scheduler: turns 1 ms timebase edges into Pac-Man / ghost step strobes,
// runs the frightened countdown and an elapsed-seconds counter under RUN/PAUSE control.
module pacman_game_timer #(
    parameter int PAC_PERIOD_MS          = 12,
    parameter int GHOST_PERIOD_MS        = 14,
    parameter int GHOST_FRIGHT_PERIOD_MS = 24,
    parameter int FRIGHT_MS              = 6000,
    parameter int WARN_MS                = 2000,
    parameter int MS_PER_SEC             = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_1ms,
    input  logic        start,
    input  logic        pause,
    input  logic        game_over,
    input  logic        fright_start,
    output logic        pac_step,
    output logic        ghost_step,
    output logic        fright_active,
    output logic        fright_warn,
    output logic        fright_end,
    output logic [15:0] elapsed_sec,
    output logic [1:0]  state
);

    localparam int GMAX = (GHOST_PERIOD_MS > GHOST_FRIGHT_PERIOD_MS) ?
                          GHOST_PERIOD_MS : GHOST_FRIGHT_PERIOD_MS;
    localparam int PW = (PAC_PERIOD_MS > 1) ? $clog2(PAC_PERIOD_MS) : 1;
    localparam int GW = (GMAX > 1) ? $clog2(GMAX) : 1;

    localparam logic [PW-1:0] PAC_TERM = PW'(PAC_PERIOD_MS - 1);
    localparam logic [GW-1:0] G_TERM   = GW'(GHOST_PERIOD_MS - 1);
    localparam logic [GW-1:0] GF_TERM  = GW'(GHOST_FRIGHT_PERIOD_MS - 1);
    localparam logic [15:0]   F_LOAD   = 16'(FRIGHT_MS);
    localparam logic [15:0]   W_LVL    = 16'(WARN_MS);
    localparam logic [9:0]    MS_TERM  = 10'(MS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic          q1_q, q1_d;
    logic          q2_q, q2_d;
    logic          primed_q, primed_d;
    logic [PW-1:0] pac_cnt_q, pac_cnt_d;
    logic [GW-1:0] ghost_cnt_q, ghost_cnt_d;
    logic [15:0]   fright_cnt_q, fright_cnt_d;
    logic          fright_active_q, fright_active_d;
    logic          fright_warn_q, fright_warn_d;
    logic          fright_end_q, fright_end_d;
    logic          pac_step_q, pac_step_d;
    logic          ghost_step_q, ghost_step_d;
    logic [9:0]    ms_acc_q, ms_acc_d;
    logic [15:0]   elapsed_q, elapsed_d;

    logic          ms_tick;
    logic          run_tick;
    logic [GW-1:0] ghost_term;

    always_comb begin
        // Until primed, q2 follows the input so a high level at reset exit is not an edge.
        q1_d     = clk_1ms;
        q2_d     = primed_q ? q1_q : clk_1ms;
        primed_d = 1'b1;
        ms_tick  = primed_q & (q1_q ^ q2_q);
        run_tick = ms_tick & (state_q == RUN);

        state_d = state_q;
        if (game_over) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (pause) state_d = PAUSED;
                PAUSED:  if (pause) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        pac_cnt_d       = pac_cnt_q;
        ghost_cnt_d     = ghost_cnt_q;
        fright_cnt_d    = fright_cnt_q;
        fright_active_d = fright_active_q;
        ms_acc_d        = ms_acc_q;
        elapsed_d       = elapsed_q;
        pac_step_d      = 1'b0;
        ghost_step_d    = 1'b0;
        fright_end_d    = 1'b0;
        ghost_term      = fright_active_q ? GF_TERM : G_TERM;

        if (game_over || state_q == IDLE) begin
            pac_cnt_d       = '0;
            ghost_cnt_d     = '0;
            fright_cnt_d    = '0;
            fright_active_d = 1'b0;
            ms_acc_d        = '0;
            elapsed_d       = '0;
        end else if (state_q == RUN) begin
            if (run_tick) begin
                if (pac_cnt_q == PAC_TERM) begin
                    pac_cnt_d  = '0;
                    pac_step_d = 1'b1;
                end else begin
                    pac_cnt_d = pac_cnt_q + 1'b1;
                end
                if (ms_acc_q == MS_TERM) begin
                    ms_acc_d = '0;
                    if (elapsed_q != 16'hFFFF) elapsed_d = elapsed_q + 1'b1;
                end else begin
                    ms_acc_d = ms_acc_q + 1'b1;
                end
            end

            if (fright_start) begin
                fright_cnt_d    = F_LOAD;
                fright_active_d = 1'b1;
            end else if (run_tick && fright_active_q) begin
                if (fright_cnt_q == 16'd1) begin
                    fright_cnt_d    = '0;
                    fright_active_d = 1'b0;
                    fright_end_d    = 1'b1;
                end else begin
                    fright_cnt_d = fright_cnt_q - 1'b1;
                end
            end

            if (fright_active_d != fright_active_q) begin
                ghost_cnt_d = '0;
            end else if (run_tick) begin
                if (ghost_cnt_q == ghost_term) begin
                    ghost_cnt_d  = '0;
                    ghost_step_d = 1'b1;
                end else begin
                    ghost_cnt_d = ghost_cnt_q + 1'b1;
                end
            end
        end

        fright_warn_d = fright_active_d && (fright_cnt_d <= W_LVL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            q1_q            <= 1'b0;
            q2_q            <= 1'b0;
            primed_q        <= 1'b0;
            pac_cnt_q       <= '0;
            ghost_cnt_q     <= '0;
            fright_cnt_q    <= '0;
            fright_active_q <= 1'b0;
            fright_warn_q   <= 1'b0;
            fright_end_q    <= 1'b0;
            pac_step_q      <= 1'b0;
            ghost_step_q    <= 1'b0;
            ms_acc_q        <= '0;
            elapsed_q       <= '0;
        end else begin
            state_q         <= state_d;
            q1_q            <= q1_d;
            q2_q            <= q2_d;
            primed_q        <= primed_d;
            pac_cnt_q       <= pac_cnt_d;
            ghost_cnt_q     <= ghost_cnt_d;
            fright_cnt_q    <= fright_cnt_d;
            fright_active_q <= fright_active_d;
            fright_warn_q   <= fright_warn_d;
            fright_end_q    <= fright_end_d;
            pac_step_q      <= pac_step_d;
            ghost_step_q    <= ghost_step_d;
            ms_acc_q        <= ms_acc_d;
            elapsed_q       <= elapsed_d;
        end
    end

    assign pac_step      = pac_step_q;
    assign ghost_step    = ghost_step_q;
    assign fright_active = fright_active_q;
    assign fright_warn   = fright_warn_q;
    assign fright_end    = fright_end_q;
    assign elapsed_sec   = elapsed_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pacman_game_timer.sv
// Directed bench for pacman_game_timer: step/fright/pause/idle vectors,
// reset priming, and elapsed-seconds saturation on a fast-second build.
module tb_pacman_game_timer;

    localparam logic [1:0] SI = 2'b00;
    localparam logic [1:0] SR = 2'b01;
    localparam logic [1:0] SP = 2'b10;

    typedef struct {
        logic       tick;
        logic       start;
        logic       pause;
        logic       fright;
        logic       go;
        logic [4:0] exp_out;
        logic [1:0] exp_st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c1ms, start, pause, game_over, fright_start;
    logic        pac_step, ghost_step, fright_active, fright_warn, fright_end;
    logic [15:0] elapsed_sec;
    logic [1:0]  state;

    logic        s_c1ms, s_start, s_zero;
    logic        s_pac, s_ghost, s_fa, s_fw, s_fe;
    logic [15:0] s_elapsed;
    logic [1:0]  s_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pacman_game_timer #(
        .PAC_PERIOD_MS(3), .GHOST_PERIOD_MS(4), .GHOST_FRIGHT_PERIOD_MS(6),
        .FRIGHT_MS(5), .WARN_MS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_1ms(c1ms), .start(start),
        .pause(pause), .game_over(game_over), .fright_start(fright_start),
        .pac_step(pac_step), .ghost_step(ghost_step),
        .fright_active(fright_active), .fright_warn(fright_warn),
        .fright_end(fright_end), .elapsed_sec(elapsed_sec), .state(state)
    );

    pacman_game_timer #(.MS_PER_SEC(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clk_1ms(s_c1ms), .start(s_start),
        .pause(s_zero), .game_over(s_zero), .fright_start(s_zero),
        .pac_step(s_pac), .ghost_step(s_ghost),
        .fright_active(s_fa), .fright_warn(s_fw),
        .fright_end(s_fe), .elapsed_sec(s_elapsed), .state(s_state)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic t, input logic s, input logic p,
                                input logic f, input logic g,
                                input logic [4:0] o, input logic [1:0] st);
        vec_t v;
        v.tick = t; v.start = s; v.pause = p; v.fright = f; v.go = g;
        v.exp_out = o; v.exp_st = st;
        return v;
    endfunction

    // Tick edge and control pulses land on the same sampling posedge.
    task automatic apply(input vec_t v, input string name);
        if (v.tick) c1ms = ~c1ms;
        @(negedge clk);
        start = v.start; pause = v.pause;
        fright_start = v.fright; game_over = v.go;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; fright_start = 1'b0; game_over = 1'b0;
        check({name, "_out"},
              32'({pac_step, ghost_step, fright_active, fright_warn, fright_end}),
              32'(v.exp_out));
        check({name, "_state"}, 32'(state), 32'(v.exp_st));
    endtask

    vec_t vecs[38];

    initial begin
        // outputs: {pac, ghost, fright_active, fright_warn, fright_end}
        vecs[0]  = mk(1,0,0,0,0, 5'b00000, SI);
        vecs[1]  = mk(1,0,0,0,0, 5'b00000, SI);
        vecs[2]  = mk(1,1,0,0,0, 5'b00000, SR);
        vecs[3]  = mk(1,0,0,0,0, 5'b00000, SR);
        vecs[4]  = mk(1,0,0,0,0, 5'b00000, SR);
        vecs[5]  = mk(1,0,0,0,0, 5'b10000, SR);
        vecs[6]  = mk(1,0,0,0,0, 5'b01000, SR);
        vecs[7]  = mk(1,0,0,1,0, 5'b00100, SR);
        vecs[8]  = mk(1,0,0,0,0, 5'b10100, SR);
        vecs[9]  = mk(1,0,0,0,0, 5'b00100, SR);
        vecs[10] = mk(1,0,0,0,0, 5'b00110, SR);
        vecs[11] = mk(1,0,0,0,0, 5'b10110, SR);
        vecs[12] = mk(1,0,0,0,0, 5'b00001, SR);
        vecs[13] = mk(1,0,0,0,0, 5'b00000, SR);
        vecs[14] = mk(1,0,0,0,0, 5'b10000, SR);
        vecs[15] = mk(1,0,0,0,0, 5'b00000, SR);
        vecs[16] = mk(1,0,0,0,0, 5'b01000, SR);
        vecs[17] = mk(1,0,0,1,0, 5'b10100, SR);
        vecs[18] = mk(1,0,0,0,0, 5'b00100, SR);
        vecs[19] = mk(1,0,0,0,0, 5'b00100, SR);
        vecs[20] = mk(1,0,0,0,0, 5'b10110, SR);
        vecs[21] = mk(1,0,0,0,0, 5'b00110, SR);
        vecs[22] = mk(1,0,0,1,0, 5'b00100, SR);
        vecs[23] = mk(1,0,0,0,0, 5'b11100, SR);
        vecs[24] = mk(1,0,1,0,0, 5'b00100, SP);
        vecs[25] = mk(1,0,0,0,0, 5'b00100, SP);
        vecs[26] = mk(1,0,0,1,0, 5'b00100, SP);
        vecs[27] = mk(1,0,1,0,0, 5'b00100, SR);
        vecs[28] = mk(1,0,0,0,0, 5'b00110, SR);
        vecs[29] = mk(1,0,0,0,0, 5'b10110, SR);
        vecs[30] = mk(1,0,0,0,0, 5'b00001, SR);
        vecs[31] = mk(1,0,0,0,1, 5'b00000, SI);
        vecs[32] = mk(1,1,0,0,1, 5'b00000, SI);
        vecs[33] = mk(1,1,0,0,0, 5'b00000, SR);
        vecs[34] = mk(1,0,0,0,0, 5'b00000, SR);
        vecs[35] = mk(1,0,0,0,0, 5'b00000, SR);
        vecs[36] = mk(1,0,0,0,0, 5'b10000, SR);
        vecs[37] = mk(1,0,0,0,1, 5'b00000, SI);

        rst_n = 1'b0; c1ms = 1'b0; start = 1'b0; pause = 1'b0;
        game_over = 1'b0; fright_start = 1'b0;
        s_c1ms = 1'b0; s_start = 1'b0; s_zero = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out",
              32'({pac_step, ghost_step, fright_active, fright_warn, fright_end}), 0);
        check("reset_state", 32'(state), 32'(SI));
        check("reset_elapsed", 32'(elapsed_sec), 0);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Step pulse lasts exactly one cycle.
        apply(mk(0,1,0,0,0, 5'b00000, SR), "restart");
        apply(mk(1,0,0,0,0, 5'b00000, SR), "pw_t1");
        apply(mk(1,0,0,0,0, 5'b00000, SR), "pw_t2");
        apply(mk(1,0,0,0,0, 5'b10000, SR), "pw_t3");
        @(negedge clk);
        check("pac_width", 32'(pac_step), 0);

        // 3 ticks so far this run; 997 more complete the first second.
        for (int i = 0; i < 996; i++) begin
            c1ms = ~c1ms;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("elapsed_999ms", 32'(elapsed_sec), 0);
        c1ms = ~c1ms;
        repeat (2) @(negedge clk);
        check("elapsed_1s", 32'(elapsed_sec), 1);

        // Reset mid-fright with the timebase high.
        apply(mk(0,0,0,1,0, 5'b00100, SR), "pre_rst_fright");
        c1ms = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_async_out",
              32'({pac_step, ghost_step, fright_active, fright_warn, fright_end}), 0);
        check("rst_async_state", 32'(state), 32'(SI));
        check("rst_async_elapsed", 32'(elapsed_sec), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_state", 32'(state), 32'(SR));
        apply(mk(1,0,0,0,0, 5'b00000, SR), "prime_t1");
        apply(mk(1,0,0,0,0, 5'b00000, SR), "prime_t2");
        apply(mk(1,0,0,0,0, 5'b10000, SR), "prime_t3");

        // Saturation: one second per tick on the fast build.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("sat_state", 32'(s_state), 32'(SR));
        for (int i = 0; i < 100; i++) begin
            s_c1ms = ~s_c1ms;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("sat_100", 32'(s_elapsed), 100);
        for (int i = 0; i < 65434; i++) begin
            s_c1ms = ~s_c1ms;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("sat_65534", 32'(s_elapsed), 65534);
        s_c1ms = ~s_c1ms;
        repeat (2) @(negedge clk);
        check("sat_65535", 32'(s_elapsed), 65535);
        for (int i = 0; i < 10; i++) begin
            s_c1ms = ~s_c1ms;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("sat_hold", 32'(s_elapsed), 65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
